// File: rtl/game_flow_ctl.sv
// Labyrinth game sequencer: gates held keys into one move pulse per step tick,
// keeps the position block (user_pos_ctl) in reset between rounds, counts lives
// on obstacle hits, and flags goal / game-over. Every output is registered.
module game_flow_ctl #(
  parameter int unsigned TICK_DIV       = 65000,  // clk cycles per move step (>=2)
  parameter int unsigned LIVES          = 3,      // lives at game start (1..15)
  parameter int unsigned RESPAWN_CYCLES = 1000,   // position-reset hold after a hit (>=1)
  parameter int unsigned GOAL_X         = 600,    // goal region lower x bound (inclusive)
  parameter int unsigned GOAL_Y         = 400     // goal region lower y bound (inclusive)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  keys_in,    // {U,D,R,L}
  input  logic        hit,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [3:0]  keys_out,   // {U,D,R,L}, one-hot or zero
  output logic        pos_rst,
  output logic [3:0]  lives,
  output logic [2:0]  state,
  output logic        win,
  output logic        game_over
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned RESP_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'(RESPAWN_CYCLES - 1);
  localparam logic [3:0]        LIVES_INIT = 4'(LIVES);
  localparam logic [11:0]       GOAL_X_12  = 12'(GOAL_X);
  localparam logic [11:0]       GOAL_Y_12  = 12'(GOAL_Y);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_RESPAWN = 3'd2,
    S_WIN     = 3'd3,
    S_OVER    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [3:0]        lives_q, lives_d;
  logic [3:0]        keys_q, keys_d;
  logic              pos_rst_q, pos_rst_d;
  logic              win_q, win_d;
  logic              over_q, over_d;

  logic       tick;
  logic       goal;
  logic [3:0] key_onehot;

  assign tick = (tick_q == TICK_LAST);
  assign goal = (xpos >= GOAL_X_12) && (ypos >= GOAL_Y_12);

  // Reduce held keys to a single move direction, priority U > D > R > L.
  always_comb begin
    key_onehot = 4'b0000;
    if      (keys_in[3]) key_onehot = 4'b1000;
    else if (keys_in[2]) key_onehot = 4'b0100;
    else if (keys_in[1]) key_onehot = 4'b0010;
    else if (keys_in[0]) key_onehot = 4'b0001;
  end

  // Next-state and next-output logic; outputs follow the state being entered.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    tick_d  = '0;
    resp_d  = '0;
    lives_d = lives_q;
    keys_d  = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PLAY;
      end

      S_PLAY: begin
        // Same-cycle priority: hit, then goal, then the move tick.
        if (hit) begin
          if (lives_q <= 4'd1) begin
            lives_d = 4'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 4'd1;
            state_d = S_RESPAWN;
          end
        end else if (goal) begin
          state_d = S_WIN;
        end else begin
          keys_d = tick ? key_onehot : 4'b0000;
          tick_d = tick ? '0 : tick_q + 1'b1;
        end
      end

      S_RESPAWN: begin
        // Hit is ignored here; a level still high on return to PLAY costs another life.
        if (resp_q == RESP_LAST) state_d = S_PLAY;
        else                     resp_d  = resp_q + 1'b1;
      end

      S_WIN, S_OVER: begin
        if (start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Lives are only ever reloaded while idle.
    if (state_d == S_IDLE) lives_d = LIVES_INIT;

    // The player stays visible at the goal in WIN; elsewhere outside PLAY it is held.
    pos_rst_d = (state_d == S_IDLE) || (state_d == S_RESPAWN) || (state_d == S_OVER);
    win_d     = (state_d == S_WIN);
    over_d    = (state_d == S_OVER);
  end

  // State and output registers with asynchronous reset to the idle/held condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      resp_q    <= '0;
      lives_q   <= LIVES_INIT;
      keys_q    <= 4'b0000;
      pos_rst_q <= 1'b1;
      win_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      tick_q    <= tick_d;
      resp_q    <= resp_d;
      lives_q   <= lives_d;
      keys_q    <= keys_d;
      pos_rst_q <= pos_rst_d;
      win_q     <= win_d;
      over_q    <= over_d;
    end
  end

  assign keys_out  = keys_q;
  assign pos_rst   = pos_rst_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign win       = win_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Self-checking bench for game_flow_ctl: directed scenarios followed by random
// play, all compared cycle by cycle against a behavioural game model.
module tb_game_flow_ctl;

  localparam int TD = 4;
  localparam int LV = 3;
  localparam int RC = 5;
  localparam int GX = 600;
  localparam int GY = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  keys_in;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [3:0]  keys_out;
  logic        pos_rst;
  logic [3:0]  lives;
  logic [2:0]  state;
  logic        win;
  logic        game_over;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: phase number, lives, pending move, cycles spent in the
  // current round, cycles of respawn still to serve.
  int m_state;
  int m_lives;
  int m_keys;
  int m_play;
  int m_resp;

  game_flow_ctl #(
    .TICK_DIV      (TD),
    .LIVES         (LV),
    .RESPAWN_CYCLES(RC),
    .GOAL_X        (GX),
    .GOAL_Y        (GY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .keys_in  (keys_in),
    .hit      (hit),
    .xpos     (xpos),
    .ypos     (ypos),
    .keys_out (keys_out),
    .pos_rst  (pos_rst),
    .lives    (lives),
    .state    (state),
    .win      (win),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int prio_key(input logic [3:0] k);
    for (int i = 3; i >= 0; i--) if (k[i]) return 1 << i;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_lives = LV;
    m_keys  = 0;
    m_play  = 0;
    m_resp  = 0;
  endtask

  task automatic model_step();
    m_keys = 0;
    case (m_state)
      0: if (start) begin m_state = 1; m_play = 0; end
      1: begin
        if (hit) begin
          if (m_lives <= 1) begin m_lives = 0; m_state = 4; end
          else begin m_lives = m_lives - 1; m_state = 2; m_resp = RC; end
        end else if (int'(xpos) >= GX && int'(ypos) >= GY) begin
          m_state = 3;
        end else begin
          if (m_play % TD == TD - 1) m_keys = prio_key(keys_in);
          m_play++;
        end
      end
      2: begin
        m_resp--;
        if (m_resp == 0) begin m_state = 1; m_play = 0; end
      end
      default: if (start) m_state = 0;
    endcase
    if (m_state == 0) m_lives = LV;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".state"},     int'(state),     m_state);
    check_eq({tag, ".lives"},     int'(lives),     m_lives);
    check_eq({tag, ".keys_out"},  int'(keys_out),  m_keys);
    check_eq({tag, ".pos_rst"},   int'(pos_rst),   int'(m_state == 0 || m_state == 2 || m_state == 4));
    check_eq({tag, ".win"},       int'(win),       int'(m_state == 3));
    check_eq({tag, ".game_over"}, int'(game_over), int'(m_state == 4));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic s, input logic [3:0] k, input logic h,
                       input int x, input int y);
    start   = s;
    keys_in = k;
    hit     = h;
    xpos    = 12'(x);
    ypos    = 12'(y);
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    drive(0, 4'b0000, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // 1: start pulse enters PLAY; no keys held means no moves.
    drive(1, 4'b0000, 0, 10, 10);
    cycle("t1_start");
    check_eq("t1_state_play", int'(state), 1);
    check_eq("t1_pos_rst_low", int'(pos_rst), 0);
    drive(0, 4'b0000, 0, 10, 10);
    repeat (8) cycle("t1_nokeys");

    // 2: keys 1011 held -> U pulse once every TD cycles.
    pulses = 0;
    drive(0, 4'b1011, 0, 10, 10);
    repeat (3 * TD) begin
      cycle("t2_tick");
      if (keys_out == 4'b1000) pulses++;
    end
    check_eq("t2_pulse_count", pulses, 3);

    // 3: single hit -> RESPAWN for RC cycles, then PLAY.
    drive(0, 4'b0000, 1, 10, 10);
    cycle("t3_hit");
    check_eq("t3_lives", int'(lives), 2);
    drive(0, 4'b0000, 0, 10, 10);
    repeat (RC + 2) cycle("t3_respawn");
    check_eq("t3_back_play", int'(state), 1);

    // 4: two more hits -> lives 1 then 0 and game over.
    drive(0, 4'b0000, 1, 10, 10);
    cycle("t4_hit2");
    drive(0, 4'b0000, 0, 10, 10);
    repeat (RC + 1) cycle("t4_respawn");
    drive(0, 4'b0100, 1, 10, 10);
    cycle("t4_hit3");
    check_eq("t4_game_over", int'(game_over), 1);
    drive(0, 4'b0100, 0, 10, 10);
    repeat (3) cycle("t4_over_hold");

    // 5: goal boundaries, hit beats goal, goal alone wins.
    drive(1, 4'b0000, 0, 0, 0);   cycle("t5_to_idle");
    drive(0, 4'b0000, 0, 0, 0);   cycle("t5_idle");
    drive(1, 4'b0000, 0, 0, 0);   cycle("t5_to_play");
    drive(0, 4'b0001, 0, 599, 400); cycle("t5_x_edge");
    drive(0, 4'b0001, 0, 600, 399); cycle("t5_y_edge");
    drive(0, 4'b0001, 1, 600, 400); cycle("t5_hit_goal");
    check_eq("t5_hit_wins", int'(state), 2);
    drive(0, 4'b0000, 0, 0, 0);
    repeat (RC + 1) cycle("t5_respawn");
    drive(0, 4'b0010, 0, 600, 400); cycle("t5_goal");
    check_eq("t5_win", int'(win), 1);
    drive(0, 4'b0010, 0, 600, 400);
    repeat (2) cycle("t5_win_hold");

    // 6: asynchronous reset in the middle of RESPAWN.
    drive(1, 4'b0000, 0, 0, 0); cycle("t6_to_idle");
    drive(1, 4'b0000, 0, 0, 0); cycle("t6_to_play");
    drive(0, 4'b0000, 1, 0, 0); cycle("t6_hit");
    drive(0, 4'b0000, 0, 0, 0);
    repeat (2) cycle("t6_respawn");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async_rst");
    check_eq("t6_lives", int'(lives), LV);
    cycle("t6_rst_held");
    @(negedge clk) rst = 1'b0;

    // Random play against the model.
    for (int n = 0; n < 3000; n++) begin
      int x;
      int y;
      if ($urandom % 8 == 0) begin
        x = GX + int'($urandom_range(0, 40));
        y = GY + int'($urandom_range(0, 40));
      end else if ($urandom % 2 == 0) begin
        x = int'($urandom_range(0, GX - 1));
        y = int'($urandom_range(0, 4095));
      end else begin
        x = int'($urandom_range(0, 4095));
        y = int'($urandom_range(0, GY - 1));
      end
      drive(($urandom % 25) == 0, 4'($urandom), ($urandom % 12) == 0, x, y);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
